// File: rtl/commit_unit_pkg.sv
// Shared types, op encodings and FSM state codes for the retire stage.
// Imported by commit_classify and commit_unit.
package commit_unit_pkg;

    localparam int ROB_ID_WIDTH = 4;
    localparam int REG_ADDR_W   = 5;
    localparam int REG_W        = 32;
    localparam int ADDR_W       = 32;
    localparam int ALU_OP_W     = 6;

    typedef logic [ALU_OP_W-1:0] alu_op_t;

    localparam alu_op_t ALU_OP_NOP  = 6'd0;
    localparam alu_op_t ALU_OP_ADD  = 6'd1;
    localparam alu_op_t ALU_OP_ADDI = 6'd2;
    localparam alu_op_t ALU_OP_SUB  = 6'd3;
    localparam alu_op_t ALU_OP_LUI  = 6'd4;
    localparam alu_op_t ALU_OP_JAL  = 6'd5;
    localparam alu_op_t ALU_OP_JALR = 6'd6;
    localparam alu_op_t ALU_OP_BEQ  = 6'd8;
    localparam alu_op_t ALU_OP_BNE  = 6'd9;
    localparam alu_op_t ALU_OP_BLT  = 6'd10;
    localparam alu_op_t ALU_OP_BGE  = 6'd11;
    localparam alu_op_t ALU_OP_BLTU = 6'd12;
    localparam alu_op_t ALU_OP_BGEU = 6'd13;
    localparam alu_op_t ALU_OP_LW   = 6'd16;
    localparam alu_op_t ALU_OP_SB   = 6'd20;
    localparam alu_op_t ALU_OP_SH   = 6'd21;
    localparam alu_op_t ALU_OP_SW   = 6'd22;

    localparam logic [1:0] COMMIT_IDLE    = 2'd0;
    localparam logic [1:0] COMMIT_ST_WAIT = 2'd1;
    localparam logic [1:0] COMMIT_FLUSH   = 2'd2;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
    localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

    typedef struct packed {
        logic       is_store;
        logic       is_br;
        logic       is_jalr;
        logic       writes_rd;
        logic       mispredict;
        logic [1:0] mem_size;
    } commit_class_t;

    function automatic logic [1:0] op_mem_size(input alu_op_t op);
        case (op)
            ALU_OP_SB: return MEM_SIZE_BYTE;
            ALU_OP_SH: return MEM_SIZE_HALF;
            default:   return MEM_SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/commit_classify.sv
// Pure combinational decode of the ROB head: op class, mispredict detection
// and the architecturally correct next PC.
module commit_classify
    import commit_unit_pkg::*;
(
    input  alu_op_t             op,
    input  logic [ADDR_W-1:0]   pc,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                pred,
    input  logic                outcome,
    input  logic [ADDR_W-1:0]   pred_target,
    output commit_class_t       cls,
    output logic [ADDR_W-1:0]   correct_target
);

    logic is_store;
    logic is_br;
    logic is_jalr;
    logic target_miss;

    assign is_store    = (op == ALU_OP_SB) || (op == ALU_OP_SH) || (op == ALU_OP_SW);
    assign is_br       = (op == ALU_OP_BEQ)  || (op == ALU_OP_BNE)  || (op == ALU_OP_BLT) ||
                         (op == ALU_OP_BGE)  || (op == ALU_OP_BLTU) || (op == ALU_OP_BGEU);
    assign is_jalr     = (op == ALU_OP_JALR);
    assign target_miss = (pred_target != addr);

    assign cls.is_store   = is_store;
    assign cls.is_br      = is_br;
    assign cls.is_jalr    = is_jalr;
    assign cls.writes_rd  = !is_br && !is_store;
    assign cls.mem_size   = op_mem_size(op);
    // A taken branch is only correct if the predictor also supplied the right target.
    assign cls.mispredict = (is_br && ((pred != outcome) || (outcome && target_miss))) ||
                            (is_jalr && (!pred || target_miss));

    assign correct_target = (outcome || is_jalr) ? addr : pc + ADDR_W'(4);

endmodule

// File: rtl/commit_unit.sv
// In-order retire stage: acknowledges the ROB head, writes the register file,
// performs committed stores and raises flush/redirect on mispredictions.
module commit_unit
    import commit_unit_pkg::*;
#(
    parameter int CNT_WIDTH = 32,
    parameter int ROB_IDW   = ROB_ID_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  commit_valid,
    input  logic [ROB_IDW-1:0]    commit_id,
    input  alu_op_t               commit_op,
    input  logic [REG_ADDR_W-1:0] commit_rd,
    input  logic [REG_W-1:0]      commit_value,
    input  logic [ADDR_W-1:0]     commit_pc,
    input  logic [ADDR_W-1:0]     commit_addr,
    input  logic                  commit_pred,
    input  logic                  commit_outcome,
    input  logic [ADDR_W-1:0]     commit_pred_target,
    output logic                  commit_ack,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [REG_W-1:0]      rf_wdata,
    output logic [ROB_IDW-1:0]    rf_wrob_id,
    output logic                  mem_req,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [REG_W-1:0]      mem_wdata,
    output logic [1:0]            mem_size,
    input  logic                  mem_done,
    output logic                  flush,
    output logic [ADDR_W-1:0]     redirect_pc,
    output logic [CNT_WIDTH-1:0]  cnt_retired
);

    logic [1:0]        state;
    commit_class_t     cls;
    logic [ADDR_W-1:0] correct_target;
    logic              rd_nonzero;

    commit_classify u_classify (
        .op             (commit_op),
        .pc             (commit_pc),
        .addr           (commit_addr),
        .pred           (commit_pred),
        .outcome        (commit_outcome),
        .pred_target    (commit_pred_target),
        .cls            (cls),
        .correct_target (correct_target)
    );

    assign rd_nonzero = (commit_rd != '0);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        commit_ack = 1'b0;
        rf_we      = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        rf_wrob_id = '0;
        if (rst) begin
            case (state)
                COMMIT_IDLE: begin
                    if (commit_valid && !cls.is_store) begin
                        if (!cls.mispredict) begin
                            commit_ack = 1'b1;
                            rf_we      = cls.writes_rd && rd_nonzero;
                        end else begin
                            // Mispredicted JALR still links; the branch itself is not acked.
                            rf_we = cls.is_jalr && rd_nonzero;
                        end
                    end
                end
                COMMIT_ST_WAIT: commit_ack = mem_done;
                default: ;
            endcase
        end
        if (rf_we) begin
            rf_waddr   = commit_rd;
            rf_wdata   = commit_value;
            rf_wrob_id = commit_id;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= COMMIT_IDLE;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_size    <= '0;
            flush       <= 1'b0;
            redirect_pc <= '0;
            cnt_retired <= '0;
        end else begin
            case (state)
                COMMIT_IDLE: begin
                    if (commit_valid) begin
                        if (cls.is_store) begin
                            mem_req   <= 1'b1;
                            mem_addr  <= commit_addr;
                            mem_wdata <= commit_value;
                            mem_size  <= cls.mem_size;
                            state     <= COMMIT_ST_WAIT;
                        end else if (cls.mispredict) begin
                            flush       <= 1'b1;
                            redirect_pc <= correct_target;
                            state       <= COMMIT_FLUSH;
                        end else begin
                            cnt_retired <= cnt_retired + CNT_WIDTH'(1);
                        end
                    end
                end
                COMMIT_ST_WAIT: begin
                    if (mem_done) begin
                        mem_req     <= 1'b0;
                        cnt_retired <= cnt_retired + CNT_WIDTH'(1);
                        state       <= COMMIT_IDLE;
                    end
                end
                COMMIT_FLUSH: begin
                    flush <= 1'b0;
                    state <= COMMIT_IDLE;
                end
                default: state <= COMMIT_IDLE;
            endcase
        end
    end

endmodule

// File: doc/commit_unit.md
Name: commit_unit

Overview:
- In-order retire stage at the head of the reorder buffer. Consumes the ROB commit bundle and drives `commit_ack` back to it.
- Writes architectural results to the register file and performs committed stores to data memory through a req/done handshake.
- Detects branch/JALR mispredictions at the head and raises the global `flush` plus a redirect PC to fetch.
- Sits between reorder_buffer, regfile/register-status and the memory controller.

Parameters:
- CNT_WIDTH, 32, width of the retired-instruction counter.
- ROB_IDW, `ROB_ID_WIDTH, ROB tag width (from params.v).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low (rst==0 resets on posedge clk).
- commit_valid  in  1  ROB head is ready.
- commit_id  in  ROB_IDW  head tag.
- commit_op  in  `AluOpBus  head operation.
- commit_rd  in  `RegAddrBus  destination register.
- commit_value  in  `RegBus  result, or store data for stores.
- commit_pc  in  `InstAddrBus  instruction PC.
- commit_addr  in  `InstAddrBus  store address / actual branch or JALR target.
- commit_pred  in  1  predicted taken.
- commit_outcome  in  1  actual taken.
- commit_pred_target  in  `InstAddrBus  predicted target.
- commit_ack  out  1  retire head this cycle.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  `RegAddrBus  write register.
- rf_wdata  out  `RegBus  write data.
- rf_wrob_id  out  ROB_IDW  tag; register-status clears its busy tag if equal.
- mem_req  out  1  store request, held until done.
- mem_addr  out  `InstAddrBus  store address.
- mem_wdata  out  `RegBus  store data.
- mem_size  out  2  0=byte, 1=half, 2=word.
- mem_done  in  1  store complete (single-cycle pulse).
- flush  out  1  global flush pulse.
- redirect_pc  out  `InstAddrBus  fetch restart PC, valid with flush.
- cnt_retired  out  CNT_WIDTH  retired instructions.

Behaviour:

States: IDLE, ST_WAIT, FLUSH. Reset drives state=IDLE and clears mem_req, mem_addr, mem_wdata, mem_size, flush, redirect_pc and cnt_retired to 0. Combinational outputs (commit_ack, rf_*) are 0 while rst==0.

Classification, combinational on the head:
- is_store: SB/SH/SW.
- is_br: BEQ/BNE/BLT/BGE/BLTU/BGEU.
- is_jalr.
- mispredict:
  - is_br with (pred != outcome), or (outcome==1 and pred_target != addr).
  - is_jalr with (pred==0 or pred_target != addr).
- Correct target: `commit_addr` if taken or JALR, else `commit_pc + 4` (32-bit wrap).

IDLE:
- Head not valid: no action.
- Valid, not store, not mispredict: same cycle commit_ack=1; rf_we=1 if rd!=0 and op writes rd (not branch/store); rf_waddr=rd, rf_wdata=value, rf_wrob_id=commit_id; cnt_retired+1.
- Valid store: no ack. Register mem_addr=addr, mem_wdata=value, mem_size by op; mem_req<=1; go to ST_WAIT.
- Valid mispredict: no ack (the head must still be the branch when the ROB sees flush, which its statistics rely on). For JALR with rd!=0, write the link value this cycle. Register flush<=1 and redirect_pc; go to FLUSH.

ST_WAIT:
- mem_req held with stable address, data and size.
- On mem_done: commit_ack=1 in the same cycle, mem_req<=0, cnt_retired+1, go to IDLE.
- No store is ever issued twice; a new request needs at least one idle cycle after done.

FLUSH:
- flush=1 for exactly this one cycle; commit_ack=0 and rf_we=0.
- Next cycle flush<=0 and state goes to IDLE. The mispredicted branch is discarded by the flush and not counted in cnt_retired.

Boundary cases:
- Head with rd==0 retires normally with no rf write.
- mem_done while in IDLE is ignored.
- rst low during ST_WAIT or FLUSH: everything returns to the reset values next edge, with no ack.
- cnt_retired wraps at 2^CNT_WIDTH.
- At most one commit per cycle.

Decomposition:
- Shared defines.v: op-class macros for IS_BRANCH, IS_STORE and WRITES_RD over `ALU_OP_*`; state encodings (2-bit COMMIT_IDLE/COMMIT_ST_WAIT/COMMIT_FLUSH).
- One natural sub-module: commit_classify (pure combinational op decode, mispredict detection, correct-target compute), reusable by debug/trace logic.

Test Plan:
- ADD at head, rd=5, value=0x1234, commit_valid=1 -> same cycle commit_ack=1, rf_we=1, rf_waddr=5, rf_wdata=0x1234; cnt_retired=1.
- SW at head, addr=0x100, value=0xDEADBEEF; mem_done after 3 cycles -> mem_req high for 3 cycles, mem_size=2; commit_ack only in the done cycle; then mem_req=0.
- BEQ pred=0, outcome=1, addr=0x80, pc=0x40 -> no ack; next cycle flush=1, redirect_pc=0x80 for one cycle; cnt_retired unchanged.
- BNE pred=1, outcome=0, pc=0x40 -> flush with redirect_pc=0x44. Correctly predicted BLT (pred=outcome=1, target match) -> plain ack, no flush.
- JALR rd=1, value=0x48, pred_target=0x200, addr=0x300 -> rf write x1=0x48 in the detect cycle; next cycle flush, redirect_pc=0x300.
- rst=0 asserted while in ST_WAIT -> next edge mem_req=0, state IDLE, cnt_retired=0; ADDI with rd=0 afterwards -> ack with rf_we=0.
